// File: rtl/mem_loader.sv
`default_nettype none
// =============================================================================
// mem_loader -- streams a length/word/checksum byte protocol into a 256x16 memory
// Revision 1.0
// =============================================================================
module mem_loader #(
   parameter logic [7:0] LOAD_BASE = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        mem_we,
   output logic [7:0]  mem_addr,
   output logic [15:0] mem_wdata,
   output logic        cpu_reset,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN   = 3'd1,
      S_HI    = 3'd2,
      S_LO    = 3'd3,
      S_WR    = 3'd4,
      S_CHK   = 3'd5,
      S_DONE  = 3'd6,
      S_ERROR = 3'd7
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [8:0]  remaining;
   logic [7:0]  addr;
   logic [15:0] word;
   logic [7:0]  sum;
   logic [7:0]  sum_add;
   logic        xfer;

   assign sum_add = sum + in_data;
   assign xfer    = in_valid & in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Outputs are pure state decodes so reset forces them immediately.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      mem_we     = 1'b0;
      cpu_reset  = 1'b1;
      done       = 1'b0;
      err        = 1'b0;
      case (state)
         S_IDLE: begin
            state_next = S_LEN;
         end
         S_LEN: begin
            in_ready = 1'b1;
            if (in_valid) state_next = S_HI;
         end
         S_HI: begin
            in_ready = 1'b1;
            if (in_valid) state_next = S_LO;
         end
         S_LO: begin
            in_ready = 1'b1;
            if (in_valid) state_next = S_WR;
         end
         S_WR: begin
            mem_we     = 1'b1;
            state_next = (remaining == 9'd1) ? S_CHK : S_HI;
         end
         S_CHK: begin
            in_ready = 1'b1;
            if (in_valid) state_next = (sum_add == 8'h00) ? S_DONE : S_ERROR;
         end
         S_DONE: begin
            cpu_reset = 1'b0;
            done      = 1'b1;
         end
         S_ERROR: begin
            err = 1'b1;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // A length byte of zero encodes a full 256-word image.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         remaining <= 9'd0;
         addr      <= LOAD_BASE;
         word      <= 16'h0000;
         sum       <= 8'h00;
      end else begin
         case (state)
            S_LEN: begin
               if (xfer) begin
                  remaining <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                  addr      <= LOAD_BASE;
                  sum       <= 8'h00;
               end
            end
            S_HI: begin
               if (xfer) begin
                  word[15:8] <= in_data;
                  sum        <= sum_add;
               end
            end
            S_LO: begin
               if (xfer) begin
                  word[7:0] <= in_data;
                  sum       <= sum_add;
               end
            end
            S_WR: begin
               addr      <= addr + 8'd1;
               remaining <= remaining - 9'd1;
            end
            default: begin
            end
         endcase
      end
   end

   assign mem_addr  = addr;
   assign mem_wdata = word;

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// =============================================================================
// tb_mem_loader -- self-checking bench: two loaders (base 00 and FF) on one stream
// =============================================================================
module tb_mem_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;

   logic        ready_a, we_a, cpur_a, done_a, err_a;
   logic [7:0]  addr_a;
   logic [15:0] wd_a;
   logic        ready_b, we_b, cpur_b, done_b, err_b;
   logic [7:0]  addr_b;
   logic [15:0] wd_b;

   mem_loader #(.LOAD_BASE(8'h00)) dut_a (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(ready_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a),
      .cpu_reset(cpur_a), .done(done_a), .err(err_a)
   );

   mem_loader #(.LOAD_BASE(8'hFF)) dut_b (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(ready_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
      .cpu_reset(cpur_b), .done(done_b), .err(err_b)
   );

   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   logic [7:0]  stim[$];
   logic [23:0] exp_a[$], exp_b[$], obs_a[$], obs_b[$];
   bit          exp_ok;

   // Memory-side view: the program memory samples on the falling edge.
   always @(negedge clk) begin
      if (we_a) obs_a.push_back({addr_a, wd_a});
      if (we_b) obs_b.push_back({addr_b, wd_b});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      obs_a.delete();
      obs_b.delete();
      chk("rst ready", {30'd0, ready_a, ready_b}, 32'd0);
      chk("rst we", {30'd0, we_a, we_b}, 32'd0);
      chk("rst addr_a", {24'd0, addr_a}, 32'h00);
      chk("rst addr_b", {24'd0, addr_b}, 32'hFF);
      chk("rst wdata", {wd_a, wd_b}, 32'd0);
      chk("rst flags", {26'd0, cpur_a, cpur_b, done_a, done_b, err_a, err_b}, 32'b110000);
      reset = 1'b0;
      #1;
      chk("idle ready", {31'd0, ready_a}, 32'd0);
      @(posedge clk);
      #1;
      chk("len ready", {30'd0, ready_a, ready_b}, 32'b11);
   endtask

   // Reference: words land at consecutive (wrapping) addresses; checksum covers data bytes.
   task automatic run_model();
      int n;
      int s;
      logic [15:0] w;
      exp_a.delete();
      exp_b.delete();
      n = (stim[0] == 8'h00) ? 256 : int'(stim[0]);
      s = 0;
      for (int i = 0; i < n; i++) begin
         w = {stim[1 + 2 * i], stim[2 + 2 * i]};
         s = s + int'(stim[1 + 2 * i]) + int'(stim[2 + 2 * i]);
         exp_a.push_back({8'(i), w});
         exp_b.push_back({8'(255 + i), w});
      end
      exp_ok = (((s + int'(stim[2 * n + 1])) % 256) == 0);
   endtask

   task automatic build(input int n_code, input bit good);
      int n;
      int s;
      logic [7:0] b;
      logic [7:0] c;
      n = (n_code == 0) ? 256 : n_code;
      s = 0;
      stim.delete();
      stim.push_back(8'(n_code));
      for (int i = 0; i < 2 * n; i++) begin
         b = 8'($urandom);
         s = s + int'(b);
         stim.push_back(b);
      end
      c = 8'(256 - (s % 256));
      if (!good) c = c + 8'd1;
      stim.push_back(c);
   endtask

   task automatic send(input bit rand_valid, input int abort_wr, input string tag);
      int  idx;
      int  wr;
      int  stall;
      bit  xfer;
      idx   = 0;
      wr    = 0;
      stall = 0;
      while (idx < stim.size()) begin
         in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = in_valid ? stim[idx] : 8'($urandom);
         xfer     = in_valid && ready_a;
         @(posedge clk);
         #1;
         if (xfer) begin
            idx++;
            stall = 0;
         end else begin
            stall++;
         end
         if (stall > 100) begin
            tests++;
            fails++;
            $error("FAIL %s timeout: observed byte %0d stalled, expected progress", tag, idx);
            break;
         end
         if (we_a) begin
            wr++;
            if (abort_wr != 0 && wr == abort_wr) begin
               reset = 1'b1;
               #1;
               chk({tag, " abort we"}, {30'd0, we_a, we_b}, 32'd0);
               chk({tag, " abort cpur"}, {30'd0, cpur_a, cpur_b}, 32'b11);
               in_valid = 1'b0;
               return;
            end
         end
      end
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_result(input string tag);
      chk({tag, " nw_a"}, obs_a.size(), exp_a.size());
      chk({tag, " nw_b"}, obs_b.size(), exp_b.size());
      for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++)
         chk({tag, " wr_a"}, {8'd0, obs_a[i]}, {8'd0, exp_a[i]});
      for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++)
         chk({tag, " wr_b"}, {8'd0, obs_b[i]}, {8'd0, exp_b[i]});
      chk({tag, " done"}, {30'd0, done_a, done_b}, exp_ok ? 32'b11 : 32'b00);
      chk({tag, " err"}, {30'd0, err_a, err_b}, exp_ok ? 32'b00 : 32'b11);
      chk({tag, " cpur"}, {30'd0, cpur_a, cpur_b}, exp_ok ? 32'b00 : 32'b11);
      chk({tag, " idle"}, {30'd0, ready_a, we_a}, 32'd0);
   endtask

   initial begin
      apply_reset();
      stim = '{8'h02, 8'hAA, 8'h05, 8'hBB, 8'h01, 8'h95};
      run_model();
      send(1'b0, 0, "good");
      check_result("good");

      apply_reset();
      stim = '{8'h02, 8'hAA, 8'h05, 8'hBB, 8'h01, 8'h94};
      run_model();
      send(1'b0, 0, "bad");
      check_result("bad");

      apply_reset();
      stim = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'hFD};
      run_model();
      send(1'b0, 0, "wrap");
      check_result("wrap");

      apply_reset();
      build(0, 1'b1);
      run_model();
      send(1'b0, 0, "full");
      check_result("full");

      for (int t = 0; t < 4; t++) begin
         apply_reset();
         build(int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
         run_model();
         send(1'b1, 0, "rand");
         check_result("rand");
      end

      apply_reset();
      stim = '{8'h02, 8'hAA, 8'h05, 8'hBB, 8'h01, 8'h95};
      send(1'b0, 2, "abort");
      chk("abort nw_a", obs_a.size(), 1);
      chk("abort nw_b", obs_b.size(), 1);
      if (obs_a.size() > 0) chk("abort wr_a", {8'd0, obs_a[0]}, 32'h00AA05);
      if (obs_b.size() > 0) chk("abort wr_b", {8'd0, obs_b[0]}, 32'hFFAA05);
      apply_reset();
      stim = '{8'h01, 8'h12, 8'h34, 8'hBA};
      run_model();
      send(1'b0, 0, "restart");
      check_result("restart");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
